deserializador_serie: RTL and testbench
=======================================

Name: deserializador_serie

Overview:
- Downstream consumer of the registered 4:1 bit-selector stage (`sistemas_sincronos`).
- Collects the serial bit stream that stage produces on `o_q` while its selector steps 00→01→10→11, and rebuilds the parallel word.
- Presents the word through a one-entry output register with a valid/ready handshake.
- Flags aborted frames and overruns.

Parameters:
- N, 4, word width and bits per frame (N ≥ 2).
- LSB_FIRST, 1, 1: first received bit lands in o_data[0]; 0: first bit lands in o_data[N-1].
- ERRW, 8, width of the saturating error counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high; one clock domain only.
- i_bit  in  1  serial data bit (driven from the upstream o_q).
- i_bit_valid  in  1  i_bit is sampled on this edge.
- i_start  in  1  frame start marker; meaningful only together with i_bit_valid.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_data  out  N  assembled word, held while o_valid=1.
- o_valid  out  1  o_data holds an unconsumed word.
- o_busy  out  1  a frame is partially received (state SHIFT).
- o_frame_err  out  1  one-cycle pulse: frame aborted by an early i_start.
- o_overrun  out  1  one-cycle pulse: completed word dropped because the output was full.
- o_err_count  out  ERRW  saturating count of frame_err plus overrun events.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, bit counter=0, shift register=0.
  - o_data=0, o_valid=0, o_busy=0, o_frame_err=0, o_overrun=0, o_err_count=0.
  - Reset mid-frame discards the partial frame and any held word.
- Sampling: a bit is taken only on edges with i_bit_valid=1. Edges with i_bit_valid=0 change nothing except the output handshake.
- Bit placement:
  - LSB_FIRST=1: the k-th received bit (k=0..N-1) goes to o_data[k].
  - LSB_FIRST=0: the k-th received bit goes to o_data[N-1-k].
- FSM states: IDLE, SHIFT.
  - IDLE, i_bit_valid=1 and i_start=1: sample bit 0, counter=1, go to SHIFT.
  - IDLE, i_bit_valid=1 and i_start=0: bit ignored, stay in IDLE (no error).
  - SHIFT, i_bit_valid=1 and i_start=0: sample bit k, counter+1. When this is bit N-1, the word completes, counter=0, go to IDLE.
  - SHIFT, i_bit_valid=1 and i_start=1: abort the partial frame and pulse o_frame_err. The current bit becomes bit 0 of the new frame: counter=1, stay in SHIFT.
- o_busy equals (state==SHIFT).
- Completion latency: o_valid=1 and o_data updated on the edge that samples bit N-1, so both are visible in the cycle immediately after that edge.
- Output handshake:
  - A transfer occurs when o_valid=1 and i_ready=1 at an edge.
  - o_data is stable while o_valid=1 and no transfer.
  - Transfer with no completion on the same edge: o_valid→0; o_data keeps its last value.
- Completion on the same edge as a transfer: the new word loads and o_valid stays 1. No overrun.
- Completion while o_valid=1 and i_ready=0:
  - The new word is dropped; o_data keeps the old word.
  - o_overrun pulses one cycle.
- o_err_count:
  - Increments by 1 on each o_frame_err or o_overrun pulse; the two cannot coincide.
  - Saturates at 2^ERRW−1 with no wrap.
  - Cleared only by reset.
- N=4 with the upstream selector sequence 00..11 reconstructs upstream i_data unchanged when LSB_FIRST=1.

Test Plan:
1. Basic frame:
   - Stimulus: reset, then i_start+valid with bits 1,0,0,1 on consecutive edges, i_ready=0.
   - Required: o_data=4'b1001 and o_valid=1 one cycle after the 4th edge; o_busy high for 3 cycles then low.
2. Gapped bits:
   - Stimulus: same bits with i_bit_valid=0 idle cycles between them.
   - Required: identical o_data=4'b1001; o_busy held through the gaps.
3. Early restart:
   - Stimulus: start frame 1,1, then i_start with bits 0,1,1,0.
   - Required: o_frame_err pulses once; o_data=4'b0110; o_err_count=1.
4. Overrun and back-to-back:
   - Overrun stimulus: frame A=1001 held with i_ready=0, then frame B=0011 completes.
   - Overrun required: o_overrun pulses, o_data stays 1001, o_err_count=1.
   - Back-to-back stimulus: repeat with i_ready=1 on B's completion edge.
   - Back-to-back required: o_data=0011, o_valid stays 1, no overrun.
5. Reset and bit order:
   - Stimulus: assert i_rst asynchronously after 2 bits, deassert, send a full frame 1,0,1,1.
   - Required: all outputs 0 immediately on i_rst; new frame yields 4'b1101.
   - LSB_FIRST=0 variant: same stimulus gives 4'b1011.
6. Counter saturation:
   - Stimulus: ERRW=2 with 5 consecutive aborts.
   - Required: o_err_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/deserializador_serie.sv
// ============================================================================
// Module   : deserializador_serie
// Brief    : Serial-to-parallel frame collector with a one-entry valid/ready
//            output register, abort/overrun flags and a saturating error count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module deserializador_serie #(
    parameter int N         = 4,
    parameter int LSB_FIRST = 1,
    parameter int ERRW      = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_bit,
    input  logic            i_bit_valid,
    input  logic            i_start,
    input  logic            i_ready,
    output logic [N-1:0]    o_data,
    output logic            o_valid,
    output logic            o_busy,
    output logic            o_frame_err,
    output logic            o_overrun,
    output logic [ERRW-1:0] o_err_count
);

    localparam int              CW        = $clog2(N);
    localparam logic [CW-1:0]   C_LAST    = CW'(N - 1);
    localparam logic [ERRW-1:0] C_ERR_MAX = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic [ERRW-1:0] r_err_count;

    logic            w_take;
    logic            w_abort;
    logic            w_done;
    logic            w_drop;
    logic [CW-1:0]   w_idx;
    logic [CW-1:0]   w_pos;
    logic [N-1:0]    w_word;

    always_comb begin
        w_take  = i_bit_valid && (i_start || (r_state == SHIFT));
        w_abort = i_bit_valid && i_start && (r_state == SHIFT);
        // A start marker always makes the current bit the first of a new frame.
        w_idx   = i_start ? '0 : r_cnt;
        w_pos   = (LSB_FIRST != 0) ? w_idx : (C_LAST - w_idx);
        w_word  = i_start ? '0 : r_shift;
        w_word[w_pos] = i_bit;
        w_done  = w_take && !i_start && (r_cnt == C_LAST);
        w_drop  = w_done && r_valid && !i_ready;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_frame_err <= w_abort;
            r_overrun   <= w_drop;

            if (w_take) begin
                r_shift <= w_word;
                r_cnt   <= w_done ? '0 : (w_idx + CW'(1));
                r_state <= w_done ? IDLE : SHIFT;
            end

            if ((w_abort || w_drop) && (r_err_count != C_ERR_MAX)) begin
                r_err_count <= r_err_count + ERRW'(1);
            end

            // A completion can load only if the slot is empty or drains this edge.
            if (w_done && (!r_valid || i_ready)) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_busy      = (r_state == SHIFT);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_deserializador_serie.sv
// ============================================================================
// Module   : tb_deserializador_serie
// Brief    : Scenario-based bench for deserializador_serie (LSB/MSB-first and
//            narrow-counter instances driven from one stimulus stream).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_deserializador_serie;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;

    logic [3:0] a_data, m_data, s_data;
    logic       a_valid, m_valid, s_valid;
    logic       a_busy, m_busy, s_busy;
    logic       a_ferr, m_ferr, s_ferr;
    logic       a_ovr, m_ovr, s_ovr;
    logic [7:0] a_cnt, m_cnt;
    logic [1:0] s_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_lsb_q[$];
    logic [3:0] exp_msb_q[$];

    always #5 clk = ~clk;

    deserializador_serie #(.N(4), .LSB_FIRST(1), .ERRW(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_start(start), .i_ready(ready), .o_data(a_data), .o_valid(a_valid),
        .o_busy(a_busy), .o_frame_err(a_ferr), .o_overrun(a_ovr), .o_err_count(a_cnt)
    );

    deserializador_serie #(.N(4), .LSB_FIRST(0), .ERRW(8)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_start(start), .i_ready(ready), .o_data(m_data), .o_valid(m_valid),
        .o_busy(m_busy), .o_frame_err(m_ferr), .o_overrun(m_ovr), .o_err_count(m_cnt)
    );

    deserializador_serie #(.N(4), .LSB_FIRST(1), .ERRW(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_bit(bit_in), .i_bit_valid(bit_valid),
        .i_start(start), .i_ready(ready), .o_data(s_data), .o_valid(s_valid),
        .o_busy(s_busy), .o_frame_err(s_ferr), .o_overrun(s_ovr), .o_err_count(s_cnt)
    );

    // bits[k] is the k-th bit on the wire; returns the word the block must present.
    function automatic logic [3:0] model(input logic [3:0] bits, input bit lsb);
        logic [3:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (lsb) w[k] = bits[k];
            else     w[3-k] = bits[k];
        end
        return w;
    endfunction

    task automatic step(input logic b, input logic v, input logic s, input logic r);
        bit_in = b; bit_valid = v; start = s; ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; start = 1'b0; ready = 1'b0;
        exp_lsb_q.delete();
        exp_msb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({a_data, a_valid, a_busy, a_ferr, a_ovr, a_cnt} !== 16'h0) begin
            errors++; $display("FAIL reset_lsb: got %h required 0", {a_data, a_valid, a_busy, a_ferr, a_ovr, a_cnt});
        end
        checks++;
        if ({m_data, m_valid, m_busy, m_ferr, m_ovr, m_cnt} !== 16'h0) begin
            errors++; $display("FAIL reset_msb: got %h required 0", {m_data, m_valid, m_busy, m_ferr, m_ovr, m_cnt});
        end
        checks++;
        if ({s_data, s_valid, s_busy, s_ferr, s_ovr, s_cnt} !== 10'h0) begin
            errors++; $display("FAIL reset_sat: got %h required 0", {s_data, s_valid, s_busy, s_ferr, s_ovr, s_cnt});
        end
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1001;
        logic [3:0] ea, em;
        do_reset();
        exp_lsb_q.push_back(model(bits, 1'b1));
        exp_msb_q.push_back(model(bits, 1'b0));
        for (int k = 0; k < 4; k++) begin
            step(bits[k], 1'b1, (k == 0), 1'b0);
            if (k < 3) begin
                checks++;
                if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
                    errors++; $display("FAIL basic_busy k=%0d: busy=%b valid=%b required busy=1 valid=0", k, a_busy, a_valid);
                end
            end
        end
        ea = exp_lsb_q.pop_front();
        em = exp_msb_q.pop_front();
        checks++;
        if (a_data !== ea || a_valid !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL basic_word: data=%b valid=%b busy=%b required %b 1 0", a_data, a_valid, a_busy, ea);
        end
        checks++;
        if (m_data !== em) begin
            errors++; $display("FAIL basic_word_msb: data=%b required %b", m_data, em);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (a_valid !== 1'b0 || a_data !== ea) begin
            errors++; $display("FAIL basic_drain: valid=%b data=%b required 0 %b", a_valid, a_data, ea);
        end
    endtask

    task automatic test_gapped();
        logic [3:0] bits = 4'b1001;
        logic [3:0] ea;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (a_busy !== 1'b0 || a_ferr !== 1'b0) begin
            errors++; $display("FAIL gap_stray: busy=%b ferr=%b required 0 0", a_busy, a_ferr);
        end
        exp_lsb_q.push_back(model(bits, 1'b1));
        for (int k = 0; k < 4; k++) begin
            step(bits[k], 1'b1, (k == 0), 1'b0);
            if (k < 3) begin
                step(1'b1, 1'b0, 1'b1, 1'b0);
                step(1'b0, 1'b0, 1'b0, 1'b0);
                checks++;
                if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
                    errors++; $display("FAIL gap_busy k=%0d: busy=%b valid=%b required 1 0", k, a_busy, a_valid);
                end
            end
        end
        ea = exp_lsb_q.pop_front();
        checks++;
        if (a_data !== ea || a_valid !== 1'b1) begin
            errors++; $display("FAIL gap_word: data=%b valid=%b required %b 1", a_data, a_valid, ea);
        end
    endtask

    task automatic test_restart();
        logic [3:0] bits = 4'b0110;
        logic [3:0] ea;
        int pulses = 0;
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        exp_lsb_q.push_back(model(bits, 1'b1));
        for (int k = 0; k < 4; k++) begin
            step(bits[k], 1'b1, (k == 0), 1'b0);
            if (a_ferr === 1'b1) pulses++;
            if (k == 0) begin
                checks++;
                if (a_ferr !== 1'b1 || a_busy !== 1'b1 || a_cnt !== 8'd1) begin
                    errors++; $display("FAIL restart_abort: ferr=%b busy=%b cnt=%0d required 1 1 1", a_ferr, a_busy, a_cnt);
                end
            end
        end
        ea = exp_lsb_q.pop_front();
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL restart_pulses: got %0d required 1", pulses);
        end
        checks++;
        if (a_data !== ea || a_valid !== 1'b1 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL restart_word: data=%b valid=%b cnt=%0d required %b 1 1", a_data, a_valid, a_cnt, ea);
        end
    endtask

    task automatic test_overrun();
        logic [3:0] fa = 4'b1001;
        logic [3:0] fb = 4'b0011;
        logic [3:0] ea;
        do_reset();
        exp_lsb_q.push_back(model(fa, 1'b1));
        for (int k = 0; k < 4; k++) step(fa[k], 1'b1, (k == 0), 1'b0);
        ea = exp_lsb_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            step(fb[k], 1'b1, (k == 0), 1'b0);
            if (k < 3) begin
                checks++;
                if (a_ovr !== 1'b0) begin
                    errors++; $display("FAIL ovr_early k=%0d: ovr=%b required 0", k, a_ovr);
                end
            end
        end
        checks++;
        if (a_ovr !== 1'b1 || a_data !== ea || a_valid !== 1'b1 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL ovr_drop: ovr=%b data=%b valid=%b cnt=%0d required 1 %b 1 1", a_ovr, a_data, a_valid, a_cnt, ea);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_ovr !== 1'b0 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL ovr_pulse: ovr=%b cnt=%0d required 0 1", a_ovr, a_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fa = 4'b1001;
        logic [3:0] fb = 4'b0011;
        logic [3:0] ea, em;
        do_reset();
        for (int k = 0; k < 4; k++) step(fa[k], 1'b1, (k == 0), 1'b0);
        exp_lsb_q.push_back(model(fb, 1'b1));
        exp_msb_q.push_back(model(fb, 1'b0));
        for (int k = 0; k < 4; k++) step(fb[k], 1'b1, (k == 0), (k == 3));
        ea = exp_lsb_q.pop_front();
        em = exp_msb_q.pop_front();
        checks++;
        if (a_data !== ea || a_valid !== 1'b1 || a_ovr !== 1'b0 || a_cnt !== 8'd0) begin
            errors++; $display("FAIL b2b_word: data=%b valid=%b ovr=%b cnt=%0d required %b 1 0 0", a_data, a_valid, a_ovr, a_cnt, ea);
        end
        checks++;
        if (m_data !== em) begin
            errors++; $display("FAIL b2b_word_msb: data=%b required %b", m_data, em);
        end
    endtask

    task automatic test_reset_order();
        logic [3:0] fa = 4'b1001;
        logic [3:0] fc = 4'b1101;
        logic [3:0] ea, em;
        do_reset();
        for (int k = 0; k < 4; k++) step(fa[k], 1'b1, (k == 0), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_data, a_valid, a_busy, a_ferr, a_ovr, a_cnt} !== 16'h0) begin
            errors++; $display("FAIL async_rst_lsb: got %h required 0", {a_data, a_valid, a_busy, a_ferr, a_ovr, a_cnt});
        end
        checks++;
        if ({m_data, m_valid, m_busy} !== 6'h0) begin
            errors++; $display("FAIL async_rst_msb: got %h required 0", {m_data, m_valid, m_busy});
        end
        bit_valid = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_lsb_q.push_back(model(fc, 1'b1));
        exp_msb_q.push_back(model(fc, 1'b0));
        for (int k = 0; k < 4; k++) step(fc[k], 1'b1, (k == 0), 1'b0);
        ea = exp_lsb_q.pop_front();
        em = exp_msb_q.pop_front();
        checks++;
        if (a_data !== ea || a_valid !== 1'b1) begin
            errors++; $display("FAIL order_lsb: data=%b valid=%b required %b 1", a_data, a_valid, ea);
        end
        checks++;
        if (m_data !== em || m_valid !== 1'b1) begin
            errors++; $display("FAIL order_msb: data=%b valid=%b required %b 1", m_data, m_valid, em);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] es;
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (s_cnt !== 2'd0 || s_ferr !== 1'b0) begin
            errors++; $display("FAIL sat_first: cnt=%0d ferr=%b required 0 0", s_cnt, s_ferr);
        end
        for (int i = 0; i < 5; i++) begin
            step(i[0], 1'b1, 1'b1, 1'b0);
            es = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
            checks++;
            if (s_cnt !== es || s_ferr !== 1'b1 || a_cnt !== 8'(i + 1)) begin
                errors++; $display("FAIL sat_abort%0d: sat=%0d ferr=%b wide=%0d required %0d 1 %0d", i, s_cnt, s_ferr, a_cnt, es, i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_restart();
        test_overrun();
        test_back_to_back();
        test_reset_order();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
